// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decode stage:
//   - MIPS opcode / funct constants used by the decoder
//   - alu_op codes carried in the control word
//   - o_ctrl bit positions and the packed control-word struct
//   - FSM state encoding (RUN / PEND / HALTED)
// -----------------------------------------------------------------------------
package decode_pkg;

   // Opcode and funct values the decoder distinguishes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // All-ones word parks the stage in HALTED
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   // alu_op codes
   localparam logic [1:0] ALU_OP_MEM    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
   localparam logic [1:0] ALU_OP_IMM    = 2'b11;

   // o_ctrl bit positions
   localparam int CTRL_W            = 12;
   localparam int CTRL_WB_WRITE     = 11;
   localparam int CTRL_MEM_TO_REG   = 10;
   localparam int CTRL_MEM_READ     = 9;
   localparam int CTRL_MEM_WRITE    = 8;
   localparam int CTRL_MEM_UNSIGNED = 7;
   localparam int CTRL_MEM_SIZE_HI  = 6;
   localparam int CTRL_MEM_SIZE_LO  = 5;
   localparam int CTRL_ALU_SRC      = 4;
   localparam int CTRL_REG_DST      = 3;
   localparam int CTRL_ALU_OP_HI    = 2;
   localparam int CTRL_ALU_OP_LO    = 1;
   localparam int CTRL_IS_LINK      = 0;

   // Field order matches the bit positions above (MSB first)
   typedef struct packed {
      logic       wb_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       mem_unsigned;
      logic [1:0] mem_size;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       is_link;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PEND   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Register file with two asynchronous read ports and one synchronous write
// port. Register 0 reads as zero and ignores writes.
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_addr_a / o_data_a       read port A
//   i_addr_b / o_data_b       read port B
//   i_we, i_waddr, i_wdata    write port (rising edge)
// -----------------------------------------------------------------------------
module regfile_2r1w #(
   parameter int NB_DATA     = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [NB_REG_ADDR-1:0] i_addr_a,
   output logic [NB_DATA-1:0]     o_data_a,
   input  logic [NB_REG_ADDR-1:0] i_addr_b,
   output logic [NB_DATA-1:0]     o_data_b,
   input  logic                   i_we,
   input  logic [NB_REG_ADDR-1:0] i_waddr,
   input  logic [NB_DATA-1:0]     i_wdata
);

   localparam int NUM_REGS = 2**NB_REG_ADDR;

   logic [NB_DATA-1:0] regs [NUM_REGS];

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         // NOTE: the array is cleared on reset, which forces it into flops
         // rather than a RAM macro; acceptable for a 32-entry regfile.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         regs[i_waddr] <= i_wdata;
      end
   end

   assign o_data_a = (i_addr_a == '0) ? '0 : regs[i_addr_a];
   assign o_data_b = (i_addr_b == '0) ? '0 : regs[i_addr_b];

endmodule

// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
// MIPS decode stage: reads operands, builds the control word, resolves
// jumps/branches combinationally and registers the decoded bundle behind a
// valid/ready handshake. A RUN/PEND/HALTED FSM parks the stage after the
// all-ones halt word until i_resume.
// Optional feature: define DECODE_WB_BYPASS_EN to forward a same-cycle
// register write into the operands and the branch compare.
// Ports:
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_valid/o_ready, i_instruction, i_pc4   upstream handshake and payload
//   i_stall, i_flush, i_resume       hazard bubble, discard, leave HALTED
//   i_wb_we/i_wb_addr/i_wb_data      register write port
//   o_valid/i_ready + o_ra..o_ctrl   downstream handshake and bundle
//   o_jump, o_jump_addr              combinational redirect
//   o_halt                           stage is HALTED
// -----------------------------------------------------------------------------
module instruction_decode_stage
   import decode_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_PC       = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [31:0]            i_instruction,
   input  logic [NB_PC-1:0]       i_pc4,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic                   i_resume,
   input  logic                   i_wb_we,
   input  logic [NB_REG_ADDR-1:0] i_wb_addr,
   input  logic [NB_DATA-1:0]     i_wb_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [NB_DATA-1:0]     o_ra,
   output logic [NB_DATA-1:0]     o_rb,
   output logic [NB_DATA-1:0]     o_imm,
   output logic [NB_REG_ADDR-1:0] o_rs,
   output logic [NB_REG_ADDR-1:0] o_rt,
   output logic [NB_REG_ADDR-1:0] o_rd,
   output logic [4:0]             o_shamt,
   output logic [5:0]             o_opcode,
   output logic [5:0]             o_funct,
   output logic [CTRL_W-1:0]      o_ctrl,
   output logic                   o_jump,
   output logic [NB_PC-1:0]       o_jump_addr,
   output logic                   o_halt
);

   // ---------------- instruction fields ----------------
   logic [5:0]             opcode, funct;
   logic [NB_REG_ADDR-1:0] rs_addr, rt_addr, rd_addr;

   assign opcode  = i_instruction[31:26];
   assign funct   = i_instruction[5:0];
   assign rs_addr = NB_REG_ADDR'(i_instruction[25:21]);
   assign rt_addr = NB_REG_ADDR'(i_instruction[20:16]);
   assign rd_addr = NB_REG_ADDR'(i_instruction[15:11]);

   // ---------------- operand read ----------------
   logic [NB_DATA-1:0] rf_data_a, rf_data_b, rs_val, rt_val;

   regfile_2r1w #(
      .NB_DATA     (NB_DATA),
      .NB_REG_ADDR (NB_REG_ADDR)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_addr_a  (rs_addr),
      .o_data_a  (rf_data_a),
      .i_addr_b  (rt_addr),
      .o_data_b  (rf_data_b),
      .i_we      (i_wb_we),
      .i_waddr   (i_wb_addr),
      .i_wdata   (i_wb_data)
   );

`ifdef DECODE_WB_BYPASS_EN
   logic wb_hit;
   assign wb_hit = i_wb_we && (i_wb_addr != '0);
   assign rs_val = (wb_hit && (i_wb_addr == rs_addr)) ? i_wb_data : rf_data_a;
   assign rt_val = (wb_hit && (i_wb_addr == rt_addr)) ? i_wb_data : rf_data_b;
`else
   assign rs_val = rf_data_a;
   assign rt_val = rf_data_b;
`endif

   // ---------------- instruction classes ----------------
   logic is_rtype, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne;
   logic is_mem, is_load, is_store, is_imm, is_halt;

   assign is_rtype = (opcode == OP_RTYPE);
   assign is_jr    = is_rtype && (funct == FN_JR);
   assign is_jalr  = is_rtype && (funct == FN_JALR);
   assign is_j     = (opcode == OP_J);
   assign is_jal   = (opcode == OP_JAL);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_bne   = (opcode == OP_BNE);
   assign is_mem   = opcode[5];
   assign is_load  = is_mem && !opcode[3];
   assign is_store = is_mem && opcode[3];
   assign is_imm   = (opcode[5:3] == 3'b001);
   assign is_halt  = (i_instruction == HALT_INSTR);

   // ---------------- control word ----------------
   ctrl_t ctrl;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      ctrl              = '0;
      ctrl.wb_write     = (is_rtype && !is_jr) || is_jal || is_load || is_imm;
      ctrl.mem_to_reg   = !is_load;
      ctrl.mem_read     = is_load;
      ctrl.mem_write    = is_store;
      ctrl.alu_src      = is_mem || is_imm;
      ctrl.reg_dst      = is_rtype;
      ctrl.is_link      = is_jal || is_jalr;
      if (is_mem) begin
         ctrl.mem_unsigned = opcode[2];
         ctrl.mem_size     = opcode[1:0];
      end
      if (is_rtype)              ctrl.alu_op = ALU_OP_RTYPE;
      else if (is_mem)           ctrl.alu_op = ALU_OP_MEM;
      else if (is_imm || is_jal) ctrl.alu_op = ALU_OP_IMM;
      else                       ctrl.alu_op = ALU_OP_BRANCH;
   end

   // Link instructions carry the return address in place of rs
   logic [NB_DATA-1:0]     ra_next, imm_ext;
   logic [NB_REG_ADDR-1:0] rs_next, rt_next;

   assign ra_next = ctrl.is_link ? NB_DATA'(i_pc4) : rs_val;
   assign rs_next = ctrl.is_link ? '0 : rs_addr;
   assign rt_next = is_jal ? NB_REG_ADDR'(31) : rt_addr;
   assign imm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

   // ---------------- redirect ----------------
   logic [NB_PC-1:0] br_off, br_tgt, j_tgt;
   logic             jump_taken, accept;

   assign br_off = {{(NB_PC-16){i_instruction[15]}}, i_instruction[15:0]} << 2;
   assign br_tgt = i_pc4 + br_off;
   // Keep PC bits above 28, replace the low 28 with the word index
   assign j_tgt  = (i_pc4 & ~NB_PC'(28'hFFF_FFFF)) | NB_PC'({i_instruction[25:0], 2'b00});

   assign jump_taken = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))
                     || is_j || is_jal || is_jr || is_jalr;

   always_comb begin
      if (is_jr || is_jalr)    o_jump_addr = NB_PC'(rs_val);
      else if (is_j || is_jal) o_jump_addr = j_tgt;
      else                     o_jump_addr = br_tgt;
   end

   assign accept = i_valid && o_ready && !i_stall && !i_flush;
   assign o_jump = accept && jump_taken;

   // ---------------- FSM ----------------
   state_t state, state_next;
   logic   run;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_RUN;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:    if (accept && is_halt) state_next = ST_PEND;
         ST_PEND:   if (i_flush)           state_next = ST_RUN;
                    else if (!o_valid)     state_next = ST_HALTED;
         ST_HALTED: if (i_resume)          state_next = ST_RUN;
         default:                          state_next = ST_RUN;
      endcase
   end

   always_comb begin
      run    = (state == ST_RUN);
      o_halt = (state == ST_HALTED);
   end

   assign o_ready = run && (!o_valid || i_ready);

   // ---------------- output register ----------------
   // A bubble only clears valid and ctrl; the data fields are don't-care then.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid  <= 1'b0;
         o_ctrl   <= '0;
         o_ra     <= '0;
         o_rb     <= '0;
         o_imm    <= '0;
         o_rs     <= '0;
         o_rt     <= '0;
         o_rd     <= '0;
         o_shamt  <= '0;
         o_opcode <= '0;
         o_funct  <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
         o_ctrl  <= '0;
      end else if (accept && !is_halt) begin
         o_valid  <= 1'b1;
         o_ctrl   <= ctrl;
         o_ra     <= ra_next;
         o_rb     <= rt_val;
         o_imm    <= imm_ext;
         o_rs     <= rs_next;
         o_rt     <= rt_next;
         o_rd     <= rd_addr;
         o_shamt  <= i_instruction[10:6];
         o_opcode <= opcode;
         o_funct  <= funct;
      end else if (o_ready) begin
         o_valid <= 1'b0;
         o_ctrl  <= '0;
      end
   end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode_stage
// Directed steps followed by a randomized instruction stream, compared against
// a behavioural reference model of the decode rules.
// -----------------------------------------------------------------------------
module tb_instruction_decode_stage;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_valid, o_ready;
   logic [31:0] i_instruction, i_pc4;
   logic        i_stall, i_flush, i_resume;
   logic        i_wb_we;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_valid, i_ready;
   logic [31:0] o_ra, o_rb, o_imm;
   logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
   logic [5:0]  o_opcode, o_funct;
   logic [11:0] o_ctrl;
   logic        o_jump;
   logic [31:0] o_jump_addr;
   logic        o_halt;

   int n_pass   = 0;
   int n_checks = 0;

   logic [31:0] mregs [32];

   instruction_decode_stage dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_instruction(i_instruction), .i_pc4(i_pc4),
      .i_stall(i_stall), .i_flush(i_flush), .i_resume(i_resume),
      .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_ra(o_ra), .o_rb(o_rb), .o_imm(o_imm),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
      .o_opcode(o_opcode), .o_funct(o_funct), .o_ctrl(o_ctrl),
      .o_jump(o_jump), .o_jump_addr(o_jump_addr), .o_halt(o_halt)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
      tick();
      i_wb_we = 1'b0;
      if (a != 0) mregs[a] = d;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Reference control word from the instruction-class rules
   function automatic logic [11:0] ref_ctrl(input logic [31:0] ins);
      logic [5:0] op, fn;
      logic       wb, m2r, mr, mw, mu, as, rdst, lnk;
      logic [1:0] ms, aop;
      op = ins[31:26]; fn = ins[5:0];
      wb = 0; m2r = 1; mr = 0; mw = 0; mu = 0; as = 0; rdst = 0; lnk = 0;
      ms = 0; aop = 2'b01;
      if (op == 6'h00) begin
         rdst = 1; aop = 2'b10; wb = (fn != 6'h08); lnk = (fn == 6'h09);
      end else if (op >= 6'h20 && op <= 6'h27) begin
         wb = 1; m2r = 0; mr = 1; mu = op[2]; ms = op[1:0]; as = 1; aop = 2'b00;
      end else if (op >= 6'h28 && op <= 6'h2F) begin
         mw = 1; mu = op[2]; ms = op[1:0]; as = 1; aop = 2'b00;
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         wb = 1; as = 1; aop = 2'b11;
      end else if (op == 6'h03) begin
         wb = 1; aop = 2'b11; lnk = 1;
      end
      return {wb, m2r, mr, mw, mu, ms, as, rdst, aop, lnk};
   endfunction

   logic [5:0] imm_ops [5] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F};
   logic [5:0] ld_ops  [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
   logic [5:0] st_ops  [3] = '{6'h28, 6'h29, 6'h2B};
   logic [5:0] r_fns   [4] = '{6'h20, 6'h22, 6'h25, 6'h2A};

   initial begin
      logic [31:0] ins, pc4, r, a, b, sx, tgt, exp_ra;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  op, fn;
      logic [11:0] ectrl;
      logic        taken;
      int          k;

      for (int i = 0; i < 32; i++) mregs[i] = 0;
      i_reset_n = 0; i_valid = 0; i_instruction = 0; i_pc4 = 0;
      i_stall = 0; i_flush = 0; i_resume = 0; i_ready = 1;
      i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;

      // ---- reset state ----
      #2;
      check("rst_valid", o_valid, 0);
      check("rst_ctrl", o_ctrl, 0);
      check("rst_halt", o_halt, 0);
      check("rst_ready", o_ready, 1);
      check("rst_ra", o_ra, 0);
      tick();
      i_reset_n = 1;

      // ---- ADD r3,r1,r2 ----
      wr_reg(1, 5);
      wr_reg(2, 7);
      wr_reg(0, 32'hDEAD);
      i_instruction = rtype(1, 2, 3, 6'h20); i_valid = 1;
      tick();
      check("add_valid", o_valid, 1);
      check("add_ra", o_ra, 5);
      check("add_rb", o_rb, 7);
      check("add_rd", o_rd, 3);
      check("add_reg_dst", o_ctrl[3], 1);
      check("add_alu_op", o_ctrl[2:1], 2'b10);
      check("add_wb_write", o_ctrl[11], 1);

      // ---- r0 reads zero after write attempt ----
      i_instruction = rtype(0, 1, 5, 6'h20);
      tick();
      check("r0_ra", o_ra, 0);
      check("r0_rb", o_rb, 5);

      // ---- BEQ taken, then stalled ----
      i_instruction = itype(6'h04, 1, 1, 16'hFFFE); i_pc4 = 32'h100;
      #1;
      check("beq_jump", o_jump, 1);
      check("beq_addr", o_jump_addr, 32'hF8);
      tick();
      check("beq_valid", o_valid, 1);
      i_stall = 1;
      #1;
      check("stall_jump", o_jump, 0);
      tick();
      check("stall_bubble_valid", o_valid, 0);
      check("stall_bubble_ctrl", o_ctrl, 0);
      i_stall = 0;

      // ---- LW held under backpressure ----
      i_instruction = itype(6'h23, 1, 6, 16'd4);
      tick();
      check("lw_valid", o_valid, 1);
      check("lw_ctrl", o_ctrl, 12'hA70);
      i_ready = 0; i_instruction = rtype(1, 2, 3, 6'h20);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_ready", o_ready, 0);
         tick();
         check("bp_valid", o_valid, 1);
         check("bp_opcode", o_opcode, 6'h23);
         check("bp_imm", o_imm, 4);
      end
      i_ready = 1;
      #1;
      check("bp_release_ready", o_ready, 1);
      tick();
      check("bp_next_opcode", o_opcode, 0);
      check("bp_next_valid", o_valid, 1);

      // ---- halt / resume ----
      i_instruction = 32'hFFFF_FFFF;
      tick();
      check("halt_bubble", o_valid, 0);
      check("pend_ready", o_ready, 0);
      check("pend_halt", o_halt, 0);
      i_instruction = rtype(1, 2, 3, 6'h20);
      tick();
      check("halted", o_halt, 1);
      check("halted_ready", o_ready, 0);
      tick();
      check("halted_hold", o_halt, 1);
      check("halted_no_consume", o_valid, 0);
      i_valid = 0; i_resume = 1;
      tick();
      i_resume = 0;
      check("resume_halt", o_halt, 0);
      check("resume_ready", o_ready, 1);
      i_valid = 1;
      tick();
      check("resume_accept", o_valid, 1);
      check("resume_ra", o_ra, 5);

      // ---- same-cycle write of r4 read by ADD ----
      i_valid = 0;
      wr_reg(4, 3);
      i_valid = 1; i_instruction = rtype(4, 0, 7, 6'h20);
      i_wb_we = 1; i_wb_addr = 4; i_wb_data = 9;
      tick();
      i_wb_we = 0; mregs[4] = 9;
`ifdef DECODE_WB_BYPASS_EN
      check("bypass_ra", o_ra, 9);
`else
      check("no_bypass_ra", o_ra, 3);
`endif

      // ---- JAL ----
      i_instruction = {6'h03, 26'h000_0040}; i_pc4 = 32'h1040_0010;
      #1;
      check("jal_jump", o_jump, 1);
      check("jal_addr", o_jump_addr, 32'h1000_0100);
      tick();
      check("jal_ra", o_ra, 32'h1040_0010);
      check("jal_rs", o_rs, 0);
      check("jal_rt", o_rt, 31);
      check("jal_ctrl", o_ctrl, 12'hC07);

      // ---- flush together with stall overrides the hold ----
      i_instruction = rtype(1, 2, 3, 6'h20);
      tick();
      i_ready = 0; i_valid = 1; i_stall = 1; i_flush = 1;
      #1;
      check("flush_ready", o_ready, 0);
      tick();
      check("flush_valid", o_valid, 0);
      check("flush_ctrl", o_ctrl, 0);
      i_flush = 0; i_stall = 0; i_ready = 1; i_valid = 0;
      tick();

      // ---- randomized stream against the reference model ----
      for (int i = 1; i < 8; i++) wr_reg(i[4:0], $urandom);
      wr_reg(3, mregs[2]);
      i_valid = 1;
      for (int it = 0; it < 40; it++) begin
         k  = $urandom_range(0, 11);
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 31));
         r  = $urandom;
         case (k)
            0, 1: ins = {6'h00, rs, rt, rd, r[10:6], r_fns[$urandom_range(0, 3)]};
            2:    ins = rtype(rs, 0, 0, 6'h08);
            3:    ins = rtype(rs, 0, rd, 6'h09);
            4:    ins = {6'h02, r[25:0]};
            5:    ins = {6'h03, r[25:0]};
            6:    ins = itype(6'h04, rs, rt, r[15:0]);
            7:    ins = itype(6'h05, rs, rt, r[15:0]);
            8:    ins = itype(imm_ops[$urandom_range(0, 4)], rs, rt, r[15:0]);
            9:    ins = itype(ld_ops[$urandom_range(0, 4)], rs, rt, r[15:0]);
            10:   ins = itype(st_ops[$urandom_range(0, 2)], rs, rt, r[15:0]);
            default: ins = itype(6'h04, 2, 3, r[15:0]);
         endcase
         r   = $urandom;
         pc4 = {r[31:2], 2'b00};
         i_instruction = ins; i_pc4 = pc4;

         op = ins[31:26]; fn = ins[5:0];
         a  = mregs[ins[25:21]];
         b  = mregs[ins[20:16]];
         sx = {{16{ins[15]}}, ins[15:0]};
         taken = 0; tgt = 0;
         if (op == 6'h04)      begin taken = (a == b); tgt = pc4 + sx * 4; end
         else if (op == 6'h05) begin taken = (a != b); tgt = pc4 + sx * 4; end
         else if (op == 6'h02 || op == 6'h03) begin
            taken = 1; tgt = {pc4[31:28], ins[25:0], 2'b00};
         end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
            taken = 1; tgt = a;
         end
         ectrl  = ref_ctrl(ins);
         exp_ra = ectrl[0] ? pc4 : a;

         #1;
         check($sformatf("rnd%0d_jump", it), o_jump, taken);
         if (taken) check($sformatf("rnd%0d_jaddr", it), o_jump_addr, tgt);
         tick();
         check($sformatf("rnd%0d_valid", it), o_valid, 1);
         check($sformatf("rnd%0d_ctrl", it), o_ctrl, ectrl);
         check($sformatf("rnd%0d_ra", it), o_ra, exp_ra);
         check($sformatf("rnd%0d_rb", it), o_rb, b);
         check($sformatf("rnd%0d_imm", it), o_imm, sx);
         check($sformatf("rnd%0d_rs", it), o_rs, ectrl[0] ? 5'd0 : ins[25:21]);
         check($sformatf("rnd%0d_rt", it), o_rt, (op == 6'h03) ? 5'd31 : ins[20:16]);
         check($sformatf("rnd%0d_rd", it), o_rd, ins[15:11]);
         check($sformatf("rnd%0d_shamt", it), o_shamt, ins[10:6]);
         check($sformatf("rnd%0d_funct", it), o_funct, fn);
      end

      // ---- asynchronous reset while a bundle is valid ----
      i_instruction = rtype(1, 2, 3, 6'h20);
      tick();
      check("pre_reset_valid", o_valid, 1);
      #2;
      i_reset_n = 0;
      #1;
      check("async_reset_valid", o_valid, 0);
      check("async_reset_ctrl", o_ctrl, 0);
      tick();
      i_reset_n = 1;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      tick();
      check("post_reset_ra", o_ra, mregs[1]);
      check("post_reset_rb", o_rb, mregs[2]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, meaning register/operand width (at least 32).
REQ-002 SHALL have parameter NB_PC, default 32, meaning PC width (28..64).
REQ-003 SHALL have parameter NB_REG_ADDR, default 5, meaning register-address width; register count is 2**NB_REG_ADDR.
REQ-004 SHALL have ports, one per line, in this order:
i_clk  in  1  clock, all state on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage accepts instruction
i_instruction  in  32  MIPS instruction word
i_pc4  in  NB_PC  PC+4 of i_instruction
i_stall  in  1  hazard stall, insert bubble
i_flush  in  1  discard input and output contents
i_resume  in  1  leave HALTED
i_wb_we / i_wb_addr / i_wb_data  in  1 / NB_REG_ADDR / NB_DATA  register write port
o_valid  out  1  decoded bundle valid
i_ready  in  1  downstream accepts bundle
o_ra, o_rb, o_imm  out  NB_DATA  operands, sign-extended immediate
o_rs, o_rt, o_rd, o_shamt  out  NB_REG_ADDR/5  register fields
o_opcode, o_funct  out  6  opcode and funct fields
o_ctrl  out  12  {wb_write, mem_to_reg, mem_read, mem_write, mem_unsigned, mem_size[1:0], alu_src, reg_dst, alu_op[1:0], is_link}
o_jump  out  1  redirect taken
o_jump_addr  out  NB_PC  redirect target
o_halt  out  1  stage is halted

Function
REQ-005 Accept SHALL equal i_valid && o_ready && !i_stall && !i_flush; o_ready SHALL equal (state==RUN) && (!o_valid || i_ready).
REQ-006 Output register SHALL load the decoded bundle on accept; otherwise, if o_ready, it SHALL load a bubble (o_valid=0, o_ctrl=0); otherwise it SHALL hold. Latency: 1 cycle.
REQ-007 o_valid SHALL remain stable, with all outputs held, while o_valid && !i_ready.
REQ-008 i_flush SHALL clear o_valid and o_ctrl on the next edge, override accept and hold, and not change state except PEND->RUN.
REQ-009 Decode: R-type sets reg_dst=1, alu_src=0, alu_op=10; loads/stores (opcode[5]=1) set alu_op=00, mem_size=opcode[1:0], mem_unsigned=opcode[2]; immediates (opcode[5:3]=001) and JAL set alu_op=11; all others set alu_op=01.
REQ-010 wb_write SHALL be 1 for R-type (except JR), JAL, loads and immediates; mem_to_reg SHALL be 0 only for loads.
REQ-011 JAL or JALR SHALL set o_ra=zero-extended i_pc4, o_rs=0, and is_link=1; JAL SHALL set o_rt=31.
REQ-012 o_jump SHALL be combinational and asserted only on accept: BEQ/BNE when the compare holds (target=i_pc4+(imm<<2)); J/JAL with target {i_pc4[NB_PC-1:28], instr[25:0], 00}; JR/JALR with target = rs value truncated to NB_PC.
REQ-013 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-014 FSM SHALL have states RUN, PEND and HALTED: RUN->PEND on accepting 0xFFFFFFFF (a bubble is emitted, no control); PEND->HALTED when !o_valid; HALTED->RUN on i_resume; o_halt=1 only in HALTED.
REQ-015 An i_stall and i_flush in the same cycle SHALL behave as i_flush.

Reset
REQ-016 i_reset_n low SHALL asynchronously force state=RUN, o_valid=0, and all output registers and registers 1..N-1 to 0; reset mid-handshake SHALL drop the bundle.

Configuration
REQ-017 With DECODE_WB_BYPASS_EN defined, a same-cycle write with i_wb_we to a nonzero address matching rs or rt SHALL supply i_wb_data to the operands and to the branch compare; without it, reads SHALL return the pre-write value.

Structure
REQ-018 Opcode/funct constants, alu_op codes, o_ctrl bit positions and FSM encodings SHALL live in package decode_pkg.
REQ-019 The register file SHALL be sub-module regfile_2r1w (2 asynchronous read ports, 1 synchronous write port, parameters NB_DATA and NB_REG_ADDR).

Verification
REQ-020 ADD r3,r1,r2 with r1=5 and r2=7, i_ready=1 -> one cycle later o_valid=1, o_ra=5, o_rb=7, reg_dst=1, alu_op=10, wb_write=1.
REQ-021 BEQ r1,r1 with imm=-2 and i_pc4=0x100 -> same cycle o_jump=1, o_jump_addr=0xF8; with i_stall=1 -> o_jump=0 and a bubble is emitted.
REQ-022 i_ready=0 for 3 cycles with a LW in the output register -> outputs held, o_ready=0, no second instruction consumed.
REQ-023 Accept 0xFFFFFFFF -> o_halt=1 after the output stage drains, o_ready=0; i_resume pulse -> RUN and next instruction accepted.
REQ-024 Write r0=0xDEAD, then read r0 -> 0; write r4=9 the same cycle ADD reads r4 -> o_ra=9 only with DECODE_WB_BYPASS_EN.
REQ-025 Assert i_reset_n low mid-cycle while o_valid=1 -> o_valid=0 immediately, without waiting for a clock edge.
